// File: rtl/tab_stop_engine_pkg.sv
// rtl/tab_stop_engine_pkg.sv - shared terminal types and constants for tab-stop handling
package tab_stop_engine_pkg;

    localparam int CONSOLE_COLUMNS = 80;
    localparam int TAB_INTERVAL    = 8;
    localparam int TAB_COUNT_W     = 8;

    typedef enum logic [2:0] {
        TAB_SET     = 3'd0,
        TAB_CLR_CUR = 3'd1,
        TAB_CLR_ALL = 3'd2,
        TAB_DEFAULT = 3'd3,
        TAB_FWD     = 3'd4,
        TAB_BWD     = 3'd5
    } tab_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } tab_state_t;

endpackage

// File: rtl/tab_stop_bitmap.sv
// rtl/tab_stop_bitmap.sv - one stop bit per column with a write port and a combinational bit read
module tab_stop_bitmap
    import tab_stop_engine_pkg::*;
#(
    parameter int COLUMNS          = CONSOLE_COLUMNS,
    parameter int COL_W            = 8,
    parameter int DEFAULT_INTERVAL = TAB_INTERVAL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [2:0]       wr_op_i,
    input  logic [COL_W-1:0] wr_col_i,
    input  logic [COL_W-1:0] rd_col_i,
    output logic             rd_bit_o
);

    function automatic logic [COLUMNS-1:0] default_pattern();
        logic [COLUMNS-1:0] p;
        p = '0;
        for (int c = 0; c < COLUMNS; c += DEFAULT_INTERVAL) begin
            p[c] = 1'b1;
        end
        return p;
    endfunction

    localparam logic [COLUMNS-1:0] DEFAULT_PATTERN = default_pattern();

    logic [COLUMNS-1:0] bits_q;
    logic [COLUMNS-1:0] bits_d;

    // Column decode by comparison keeps indices COL_W wide without out-of-range selects.
    always_comb begin
        bits_d = bits_q;
        if (wr_en_i) begin
            case (tab_op_t'(wr_op_i))
                TAB_SET: begin
                    for (int c = 0; c < COLUMNS; c++) begin
                        if (wr_col_i == COL_W'(c)) bits_d[c] = 1'b1;
                    end
                end
                TAB_CLR_CUR: begin
                    for (int c = 0; c < COLUMNS; c++) begin
                        if (wr_col_i == COL_W'(c)) bits_d[c] = 1'b0;
                    end
                end
                TAB_CLR_ALL: bits_d = '0;
                TAB_DEFAULT: bits_d = DEFAULT_PATTERN;
                default:     bits_d = bits_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits_q <= DEFAULT_PATTERN;
        end else begin
            bits_q <= bits_d;
        end
    end

    always_comb begin
        rd_bit_o = 1'b0;
        for (int c = 0; c < COLUMNS; c++) begin
            if (rd_col_i == COL_W'(c)) rd_bit_o = bits_q[c];
        end
    end

endmodule

// File: rtl/tab_stop_engine.sv
// rtl/tab_stop_engine.sv - tab-stop command engine resolving HT/CHT/CBT motion one column per cycle
module tab_stop_engine
    import tab_stop_engine_pkg::*;
#(
    parameter int COLUMNS          = CONSOLE_COLUMNS,
    parameter int COL_W            = 8,
    parameter int DEFAULT_INTERVAL = TAB_INTERVAL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [7:0]       cmd_count,
    input  logic [COL_W-1:0] cursor_col,
    output logic             result_valid,
    output logic [COL_W-1:0] result_col
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLUMNS - 1);

    tab_state_t             state_q, state_d;
    logic [COL_W-1:0]       pos_q, pos_d;
    logic [TAB_COUNT_W-1:0] rem_q, rem_d;
    logic                   fwd_q, fwd_d;
    logic                   result_valid_q, result_valid_d;
    logic [COL_W-1:0]       result_col_q, result_col_d;

    logic             accept;
    logic [COL_W-1:0] clamped_col;
    logic [COL_W-1:0] boundary;
    logic [COL_W-1:0] step_col;
    logic             step_is_stop;

    assign accept      = cmd_valid && (state_q == ST_IDLE);
    assign clamped_col = (cursor_col > LAST_COL) ? LAST_COL : cursor_col;
    assign boundary    = fwd_q ? LAST_COL : '0;
    assign step_col    = fwd_q ? (pos_q + COL_W'(1)) : (pos_q - COL_W'(1));

    tab_stop_bitmap #(
        .COLUMNS          (COLUMNS),
        .COL_W            (COL_W),
        .DEFAULT_INTERVAL (DEFAULT_INTERVAL)
    ) u_bitmap (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en_i  (accept),
        .wr_op_i  (cmd_op),
        .wr_col_i (clamped_col),
        .rd_col_i (step_col),
        .rd_bit_o (step_is_stop)
    );

    always_comb begin
        state_d        = state_q;
        pos_d          = pos_q;
        rem_d          = rem_q;
        fwd_d          = fwd_q;
        result_valid_d = 1'b0;
        result_col_d   = result_col_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && (tab_op_t'(cmd_op) == TAB_FWD || tab_op_t'(cmd_op) == TAB_BWD)) begin
                    pos_d   = clamped_col;
                    rem_d   = (cmd_count == '0) ? TAB_COUNT_W'(1) : cmd_count;
                    fwd_d   = (tab_op_t'(cmd_op) == TAB_FWD);
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (pos_q == boundary) begin
                    result_col_d   = pos_q;
                    result_valid_d = 1'b1;
                    state_d        = ST_IDLE;
                end else begin
                    // Landing on the boundary ends the scan in the same edge, so latency equals distance.
                    pos_d = step_col;
                    if (step_is_stop) rem_d = rem_q - TAB_COUNT_W'(1);
                    if ((step_is_stop && rem_q == TAB_COUNT_W'(1)) || step_col == boundary) begin
                        result_col_d   = step_col;
                        result_valid_d = 1'b1;
                        state_d        = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            pos_q          <= '0;
            rem_q          <= '0;
            fwd_q          <= 1'b1;
            result_valid_q <= 1'b0;
            result_col_q   <= '0;
        end else begin
            state_q        <= state_d;
            pos_q          <= pos_d;
            rem_q          <= rem_d;
            fwd_q          <= fwd_d;
            result_valid_q <= result_valid_d;
            result_col_q   <= result_col_d;
        end
    end

    assign cmd_ready    = (state_q == ST_IDLE);
    assign result_valid = result_valid_q;
    assign result_col   = result_col_q;

endmodule

// File: tb/tb_tab_stop_engine.sv
// tb/tb_tab_stop_engine.sv - directed self-checking bench for tab_stop_engine
module tb_tab_stop_engine;
    import tab_stop_engine_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_count;
    logic [7:0] cursor_col;
    logic       result_valid;
    logic [7:0] result_col;

    int n_tests;
    int n_fail;

    tab_stop_engine #(
        .COLUMNS          (80),
        .COL_W            (8),
        .DEFAULT_INTERVAL (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_count    (cmd_count),
        .cursor_col   (cursor_col),
        .result_valid (result_valid),
        .result_col   (result_col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_tests++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic bitmap_op(input tab_op_t op, input logic [7:0] col, input string tag);
        @(negedge clk);
        cmd_op     = op;
        cursor_col = col;
        cmd_count  = 8'd0;
        cmd_valid  = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_novalid"}, 32'(result_valid), 32'd0);
    endtask

    task automatic motion(input tab_op_t op, input logic [7:0] cnt, input logic [7:0] col,
                          input int exp_col, input int exp_edges, input string tag);
        int  edges;
        bit  got;
        @(negedge clk);
        cmd_op     = op;
        cmd_count  = cnt;
        cursor_col = col;
        cmd_valid  = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        edges = 0;
        got   = 1'b0;
        while (!got && edges < 300) begin
            @(posedge clk);
            #1;
            edges++;
            if (result_valid) got = 1'b1;
        end
        check({tag, "_got"}, 32'(got), 32'd1);
        check({tag, "_edges"}, 32'(edges), 32'(exp_edges));
        check({tag, "_col"}, 32'(result_col), 32'(exp_col));
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_pulse1"}, 32'(result_valid), 32'd0);
    endtask

    initial begin
        int pulses, first_e, second_e, ready_e9, stray;
        n_tests    = 0;
        n_fail     = 0;
        cmd_valid  = 1'b0;
        cmd_op     = 3'd0;
        cmd_count  = 8'd0;
        cursor_col = 8'd0;
        rst_n      = 1'b0;
        #12;
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_col", 32'(result_col), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        motion(TAB_FWD, 8'd1, 8'd0, 8, 8, "fwd1_c0");
        motion(TAB_BWD, 8'd1, 8'd13, 8, 5, "bwd1_c13");
        motion(TAB_FWD, 8'd3, 8'd5, 24, 19, "fwd3_c5");
        motion(TAB_FWD, 8'd0, 8'd5, 8, 3, "fwd0_c5");

        bitmap_op(TAB_CLR_ALL, 8'd0, "clr_all");
        motion(TAB_FWD, 8'd1, 8'd10, 79, 69, "clr_fwd_c10");
        motion(TAB_BWD, 8'd1, 8'd10, 0, 10, "clr_bwd_c10");
        motion(TAB_FWD, 8'd1, 8'd79, 79, 1, "fwd_c79");

        bitmap_op(TAB_DEFAULT, 8'd0, "default1");
        bitmap_op(TAB_SET, 8'd3, "set3");
        bitmap_op(TAB_CLR_CUR, 8'd8, "clr8");
        motion(TAB_FWD, 8'd1, 8'd0, 3, 3, "edit_fwd_c0");
        motion(TAB_FWD, 8'd1, 8'd3, 16, 13, "edit_fwd_c3");
        bitmap_op(TAB_DEFAULT, 8'd0, "default2");
        motion(TAB_FWD, 8'd1, 8'd0, 8, 8, "def_fwd_c0");

        bitmap_op(tab_op_t'(3'd6), 8'd0, "noop6");
        motion(TAB_FWD, 8'd2, 8'd0, 16, 16, "noop_fwd2");

        // Held strobe during a scan plus a back-to-back command in the result cycle.
        @(negedge clk);
        cmd_op     = TAB_FWD;
        cmd_count  = 8'd1;
        cursor_col = 8'd0;
        cmd_valid  = 1'b1;
        @(posedge clk);
        #1;
        pulses   = 0;
        first_e  = 0;
        second_e = 0;
        ready_e9 = 1;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk);
            #1;
            if (result_valid) begin
                pulses++;
                if (first_e == 0) first_e = e;
                else if (second_e == 0) second_e = e;
            end
            if (e == 9) begin
                ready_e9  = int'(cmd_ready);
                cmd_valid = 1'b0;
            end
        end
        check("hold_pulses", 32'(pulses), 32'd2);
        check("hold_first", 32'(first_e), 32'd8);
        check("b2b_second", 32'(second_e), 32'd17);
        check("b2b_busy", 32'(ready_e9), 32'd0);

        // Reset in the middle of a long scan.
        bitmap_op(TAB_CLR_ALL, 8'd0, "clr_all2");
        @(negedge clk);
        cmd_op     = TAB_FWD;
        cmd_count  = 8'd1;
        cursor_col = 8'd10;
        cmd_valid  = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("midscan_busy", 32'(cmd_ready), 32'd0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(cmd_ready), 32'd1);
        check("midrst_valid", 32'(result_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int e = 0; e < 80; e++) begin
            @(posedge clk);
            #1;
            if (result_valid) stray++;
        end
        check("midrst_nopulse", 32'(stray), 32'd0);
        motion(TAB_FWD, 8'd1, 8'd0, 8, 8, "midrst_default");

        motion(TAB_FWD, 8'd1, 8'd200, 79, 1, "clamp_fwd");
        motion(TAB_BWD, 8'd1, 8'd200, 72, 7, "clamp_bwd");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
